// File: rtl/board_memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_memory_pkg                                                           |
// | Shared types, padding constants and width helpers for the playfield memory |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package board_memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } board_state_e;

    // Off-board cells: walls/floor block a piece, the sky above the board does not.
    localparam logic c_wall = 1'b1;
    localparam logic c_sky  = 1'b0;

    function automatic int calc_coord_w(input int w, input int h);
        return $clog2((w > h) ? w : h) + 1;
    endfunction

    function automatic int calc_cnt_w(input int h);
        return $clog2(h + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_block_window.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_block_window                                                         |
// | Combinational padded window extract at a signed (x,y) with in-range flags  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module board_block_window
    import board_memory_pkg::*;
#(
    parameter int width_p      = 16,
    parameter int height_p     = 16,
    parameter int block_size_p = 4,
    localparam int coord_lp    = calc_coord_w(width_p, height_p),
    localparam int cell_lp     = $clog2(width_p * height_p)
) (
    input  logic [width_p*height_p-1:0]                   field_i,
    input  logic [coord_lp-1:0]                           x_i,
    input  logic [coord_lp-1:0]                           y_i,
    output logic [block_size_p*block_size_p-1:0]          win_o,
    output logic [block_size_p*block_size_p-1:0]          in_range_o,
    output logic [block_size_p*block_size_p*cell_lp-1:0]  cell_idx_o
);

    // Wide enough that x+j never wraps and width_p/height_p stay positive.
    localparam int c_ext_w = coord_lp + $clog2(block_size_p) + 1;
    localparam int c_col_w = (width_p > 1) ? $clog2(width_p) : 1;
    localparam int c_row_w = (height_p > 1) ? $clog2(height_p) : 1;
    localparam logic signed [c_ext_w-1:0] c_w_lim = c_ext_w'(width_p);
    localparam logic signed [c_ext_w-1:0] c_h_lim = c_ext_w'(height_p);

    for (genvar i = 0; i < block_size_p; i++) begin : g_row
        for (genvar j = 0; j < block_size_p; j++) begin : g_col
            logic signed [c_ext_w-1:0] w_cx;
            logic signed [c_ext_w-1:0] w_cy;
            logic                      w_in_x;
            logic                      w_in_y;
            logic                      w_below;
            logic [cell_lp-1:0]        w_idx;

            assign w_cx    = {{(c_ext_w-coord_lp){x_i[coord_lp-1]}}, x_i} + c_ext_w'(j);
            assign w_cy    = {{(c_ext_w-coord_lp){y_i[coord_lp-1]}}, y_i} + c_ext_w'(i);
            assign w_in_x  = !w_cx[c_ext_w-1] && (w_cx < c_w_lim);
            assign w_in_y  = !w_cy[c_ext_w-1] && (w_cy < c_h_lim);
            assign w_below = !w_cy[c_ext_w-1] && !w_in_y;
            assign w_idx   = cell_lp'(w_cy[c_row_w-1:0]) * cell_lp'(width_p)
                           + cell_lp'(w_cx[c_col_w-1:0]);

            assign win_o[i*block_size_p+j]      = (w_in_x && w_in_y) ? field_i[w_idx]
                                                : ((!w_in_x || w_below) ? c_wall : c_sky);
            assign in_range_o[i*block_size_p+j] = w_in_x && w_in_y;
            assign cell_idx_o[(i*block_size_p+j)*cell_lp +: cell_lp] = w_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_memory                                                               |
// | Playfield bit-matrix: row/window reads, row/block writes, line clear FSM   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module board_memory
    import board_memory_pkg::*;
#(
    parameter int width_p      = 16,
    parameter int height_p     = 16,
    parameter int block_size_p = 4,
    parameter int num_rd_p     = 2,
    localparam int row_addr_lp = $clog2(height_p),
    localparam int coord_lp    = calc_coord_w(width_p, height_p),
    localparam int cnt_lp      = calc_cnt_w(height_p),
    localparam int blk_bits_lp = block_size_p * block_size_p
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_rd_p*row_addr_lp-1:0] rd_addr_i,
    input  logic [num_rd_p-1:0]             rd_v_i,
    output logic [num_rd_p*width_p-1:0]     rd_data_o,
    input  logic [coord_lp-1:0]             win_x_i,
    input  logic [coord_lp-1:0]             win_y_i,
    input  logic [blk_bits_lp-1:0]          win_mask_i,
    input  logic                            win_v_i,
    output logic [blk_bits_lp-1:0]          win_data_o,
    output logic                            collide_o,
    input  logic [row_addr_lp-1:0]          wr_addr_i,
    input  logic [width_p-1:0]              wr_data_i,
    input  logic                            wr_v_i,
    input  logic [coord_lp-1:0]             blk_x_i,
    input  logic [coord_lp-1:0]             blk_y_i,
    input  logic [blk_bits_lp-1:0]          blk_mask_i,
    input  logic                            blk_v_i,
    input  logic                            clear_v_i,
    output logic                            ready_o,
    output logic                            clear_done_o,
    output logic [cnt_lp-1:0]               lines_cleared_o
);

    localparam int c_cell_w = $clog2(width_p * height_p);

    logic [width_p-1:0]             r_field     [height_p];
    logic [width_p-1:0]             w_field_nxt [height_p];
    logic [width_p*height_p-1:0]    w_field_flat;
    logic [width_p*height_p-1:0]    w_blk_flat;

    board_state_e                   r_state;
    board_state_e                   w_state_nxt;
    logic [row_addr_lp-1:0]         r_src;
    logic [row_addr_lp-1:0]         r_dst;
    logic [cnt_lp-1:0]              r_cnt;
    logic [cnt_lp-1:0]              w_cnt_nxt;
    logic [cnt_lp-1:0]              r_lines;
    logic                           r_ready;
    logic                           w_ready;
    logic                           w_clear_go;
    logic                           w_row_full;

    logic [blk_bits_lp-1:0]         w_win;
    logic [blk_bits_lp-1:0]         r_win;
    logic                           r_collide;
    logic [blk_bits_lp-1:0]         w_blk_in_range;
    logic [blk_bits_lp*c_cell_w-1:0] w_blk_idx;
    logic [blk_bits_lp-1:0]         w_unused_blk_win;
    logic [blk_bits_lp-1:0]         w_unused_win_in_range;
    logic [blk_bits_lp*c_cell_w-1:0] w_unused_win_idx;

    for (genvar r = 0; r < height_p; r++) begin : g_flat
        assign w_field_flat[r*width_p +: width_p] = r_field[r];
    end

    board_block_window #(
        .width_p      (width_p),
        .height_p     (height_p),
        .block_size_p (block_size_p)
    ) u_read_win (
        .field_i    (w_field_flat),
        .x_i        (win_x_i),
        .y_i        (win_y_i),
        .win_o      (w_win),
        .in_range_o (w_unused_win_in_range),
        .cell_idx_o (w_unused_win_idx)
    );

    board_block_window #(
        .width_p      (width_p),
        .height_p     (height_p),
        .block_size_p (block_size_p)
    ) u_write_clip (
        .field_i    (w_field_flat),
        .x_i        (blk_x_i),
        .y_i        (blk_y_i),
        .win_o      (w_unused_blk_win),
        .in_range_o (w_blk_in_range),
        .cell_idx_o (w_blk_idx)
    );

    // Scatter the clipped piece mask onto a board-sized overlay.
    always_comb begin
        w_blk_flat = '0;
        for (int k = 0; k < blk_bits_lp; k++) begin
            if (blk_mask_i[k] && w_blk_in_range[k]) begin
                w_blk_flat[w_blk_idx[k*c_cell_w +: c_cell_w]] = 1'b1;
            end
        end
    end

    assign w_row_full = &r_field[r_src];
    assign w_cnt_nxt  = (r_state == COMPACT && w_row_full) ? r_cnt + cnt_lp'(1) : r_cnt;

    // Row write lands first, piece mask is ORed over it.
    always_comb begin
        for (int r = 0; r < height_p; r++) begin
            w_field_nxt[r] = r_field[r];
        end
        case (r_state)
            IDLE: begin
                if (w_ready) begin
                    for (int r = 0; r < height_p; r++) begin
                        if (wr_v_i && wr_addr_i == row_addr_lp'(r)) begin
                            w_field_nxt[r] = wr_data_i;
                        end
                        if (blk_v_i) begin
                            w_field_nxt[r] = w_field_nxt[r] | w_blk_flat[r*width_p +: width_p];
                        end
                    end
                end
            end
            COMPACT: begin
                if (!w_row_full) begin
                    w_field_nxt[r_dst] = r_field[r_src];
                end
            end
            FILL:    w_field_nxt[r_dst] = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < height_p; r++) begin
                r_field[r] <= '0;
            end
        end else begin
            for (int r = 0; r < height_p; r++) begin
                r_field[r] <= w_field_nxt[r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_clear_go) w_state_nxt = COMPACT;
            COMPACT: if (r_src == '0) w_state_nxt = (w_cnt_nxt != '0) ? FILL : DONE;
            FILL:    if (r_dst == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready      = r_ready && (r_state == IDLE);
        w_clear_go   = w_ready && clear_v_i;
        clear_done_o = (r_state == DONE);
    end

    assign ready_o         = w_ready;
    assign lines_cleared_o = r_lines;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_lines <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == IDLE);
            r_cnt   <= w_cnt_nxt;
            case (r_state)
                IDLE: begin
                    if (w_clear_go) begin
                        r_src <= row_addr_lp'(height_p - 1);
                        r_dst <= row_addr_lp'(height_p - 1);
                        r_cnt <= '0;
                    end
                end
                COMPACT: begin
                    r_src <= r_src - row_addr_lp'(1);
                    if (!w_row_full) r_dst <= r_dst - row_addr_lp'(1);
                end
                FILL:    r_dst <= r_dst - row_addr_lp'(1);
                default: ;
            endcase
            // Loaded on entry to DONE so the count is valid alongside the pulse.
            if (w_state_nxt == DONE && r_state != DONE) r_lines <= w_cnt_nxt;
        end
    end

    for (genvar p = 0; p < num_rd_p; p++) begin : g_rd
        logic [row_addr_lp-1:0] w_addr;
        logic [width_p-1:0]     r_data;

        assign w_addr = rd_addr_i[p*row_addr_lp +: row_addr_lp];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_data <= '0;
            end else if (rd_v_i[p]) begin
                r_data <= ({1'b0, w_addr} < (row_addr_lp+1)'(height_p)) ? r_field[w_addr] : '0;
            end
        end

        assign rd_data_o[p*width_p +: width_p] = r_data;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_win     <= '0;
            r_collide <= 1'b0;
        end else if (win_v_i) begin
            r_win     <= w_win;
            r_collide <= |(w_win & win_mask_i);
        end
    end

    assign win_data_o = r_win;
    assign collide_o  = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_board_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_board_memory                                                            |
// | Directed vector bench for the playfield memory                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_board_memory;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [7:0]  rd_addr_i;
    logic [1:0]  rd_v_i;
    logic [31:0] rd_data_o;
    logic [4:0]  win_x_i, win_y_i;
    logic [15:0] win_mask_i;
    logic        win_v_i;
    logic [15:0] win_data_o;
    logic        collide_o;
    logic [3:0]  wr_addr_i;
    logic [15:0] wr_data_i;
    logic        wr_v_i;
    logic [4:0]  blk_x_i, blk_y_i;
    logic [15:0] blk_mask_i;
    logic        blk_v_i;
    logic        clear_v_i;
    logic        ready_o;
    logic        clear_done_o;
    logic [4:0]  lines_cleared_o;

    board_memory dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .rd_addr_i       (rd_addr_i),
        .rd_v_i          (rd_v_i),
        .rd_data_o       (rd_data_o),
        .win_x_i         (win_x_i),
        .win_y_i         (win_y_i),
        .win_mask_i      (win_mask_i),
        .win_v_i         (win_v_i),
        .win_data_o      (win_data_o),
        .collide_o       (collide_o),
        .wr_addr_i       (wr_addr_i),
        .wr_data_i       (wr_data_i),
        .wr_v_i          (wr_v_i),
        .blk_x_i         (blk_x_i),
        .blk_y_i         (blk_y_i),
        .blk_mask_i      (blk_mask_i),
        .blk_v_i         (blk_v_i),
        .clear_v_i       (clear_v_i),
        .ready_o         (ready_o),
        .clear_done_o    (clear_done_o),
        .lines_cleared_o (lines_cleared_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  x;
        logic [4:0]  y;
        logic [15:0] mask;
        logic [15:0] exp_win;
        logic        exp_col;
    } win_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic read_row(input int a, output logic [15:0] d);
        rd_addr_i[3:0] = 4'(a);
        rd_v_i[0]      = 1'b1;
        tick();
        d         = rd_data_o[15:0];
        rd_v_i[0] = 1'b0;
    endtask

    task automatic write_row(input int a, input logic [15:0] d);
        wr_addr_i = 4'(a);
        wr_data_i = d;
        wr_v_i    = 1'b1;
        tick();
        wr_v_i    = 1'b0;
    endtask

    // Counts edges from the accepting edge (edge 1) until clear_done_o is seen.
    task automatic run_clear(input bit busy_wr, output int n);
        bit seen;
        seen      = 1'b0;
        n         = 0;
        clear_v_i = 1'b1;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                clear_v_i = 1'b0;
                check("ready_low_while_busy", 32'(ready_o), 32'd0);
                if (busy_wr) begin
                    wr_addr_i  = 4'd0;
                    wr_data_i  = 16'hAAAA;
                    wr_v_i     = 1'b1;
                    blk_x_i    = 5'd0;
                    blk_y_i    = 5'd0;
                    blk_mask_i = 16'h0001;
                    blk_v_i    = 1'b1;
                    clear_v_i  = 1'b1;
                end
            end else if (n == 2) begin
                wr_v_i    = 1'b0;
                blk_v_i   = 1'b0;
                clear_v_i = 1'b0;
            end
            if (clear_done_o) seen = 1'b1;
        end
    endtask

    initial begin
        win_vec_t    wv [8];
        logic [15:0] exp_rows [16];
        logic [15:0] d;
        int          n;
        bit          seen;

        reset_n_i  = 1'b0;
        rd_addr_i  = '0;
        rd_v_i     = '0;
        win_x_i    = '0;
        win_y_i    = '0;
        win_mask_i = '0;
        win_v_i    = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        wr_v_i     = 1'b0;
        blk_x_i    = '0;
        blk_y_i    = '0;
        blk_mask_i = '0;
        blk_v_i    = 1'b0;
        clear_v_i  = 1'b0;

        // Board for these windows: rows 0..2 = 0x0007, everything else empty.
        wv[0] = '{5'd14, 5'd13, 16'hFFFF, 16'hFCCC, 1'b1};
        wv[1] = '{5'd4,  5'h1E, 16'hFFFF, 16'h0000, 1'b0};
        wv[2] = '{5'h1F, 5'h1F, 16'hFFFF, 16'hFFF1, 1'b1};
        wv[3] = '{5'd0,  5'd0,  16'h8000, 16'h0777, 1'b0};
        wv[4] = '{5'd0,  5'd0,  16'h0001, 16'h0777, 1'b1};
        wv[5] = '{5'd2,  5'h1F, 16'h0010, 16'h1110, 1'b1};
        wv[6] = '{5'h1C, 5'd0,  16'h0000, 16'hFFFF, 1'b0};
        wv[7] = '{5'd13, 5'h1D, 16'h7777, 16'h8888, 1'b0};

        exp_rows = '{16'h0000, 16'h0000, 16'h0007, 16'h0007, 16'h0007, 16'h0000,
                     16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, 16'h8001, 16'h00F0};

        repeat (3) tick();
        check("rst_rd_data",  rd_data_o,               32'd0);
        check("rst_win_data", 32'(win_data_o),         32'd0);
        check("rst_collide",  32'(collide_o),          32'd0);
        check("rst_done",     32'(clear_done_o),       32'd0);
        check("rst_lines",    32'(lines_cleared_o),    32'd0);
        check("rst_ready",    32'(ready_o),            32'd0);
        reset_n_i = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(ready_o), 32'd0);
        tick();
        check("ready_after_first_edge",  32'(ready_o), 32'd1);

        blk_x_i    = 5'h1F;
        blk_y_i    = 5'h1F;
        blk_mask_i = 16'hFFFF;
        blk_v_i    = 1'b1;
        tick();
        blk_v_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            read_row(r, d);
            check($sformatf("clip_row%0d", r), 32'(d), (r < 3) ? 32'h0007 : 32'h0000);
        end

        for (int i = 0; i < 8; i++) begin
            win_x_i    = wv[i].x;
            win_y_i    = wv[i].y;
            win_mask_i = wv[i].mask;
            win_v_i    = 1'b1;
            tick();
            check($sformatf("win%0d_data", i),    32'(win_data_o), 32'(wv[i].exp_win));
            check($sformatf("win%0d_collide", i), 32'(collide_o),  32'(wv[i].exp_col));
        end
        win_x_i    = 5'd0;
        win_y_i    = 5'd0;
        win_mask_i = 16'h0001;
        win_v_i    = 1'b0;
        tick();
        check("win_hold_data",    32'(win_data_o), 32'h8888);
        check("win_hold_collide", 32'(collide_o),  32'd0);

        write_row(5, 16'h1234);
        wr_addr_i  = 4'd5;
        wr_data_i  = 16'h0F00;
        wr_v_i     = 1'b1;
        blk_x_i    = 5'd0;
        blk_y_i    = 5'd4;
        blk_mask_i = 16'h00F0;
        blk_v_i    = 1'b1;
        rd_addr_i[7:4] = 4'd5;
        rd_v_i[1]  = 1'b1;
        tick();
        wr_v_i    = 1'b0;
        blk_v_i   = 1'b0;
        rd_v_i[1] = 1'b0;
        check("same_cycle_read_old", 32'(rd_data_o[31:16]), 32'h1234);
        read_row(5, d);
        check("row_then_block_row5", 32'(d), 32'h0F0F);
        read_row(4, d);
        check("row_then_block_row4", 32'(d), 32'h0000);

        write_row(15, 16'hFFFF);
        write_row(14, 16'h00F0);
        write_row(13, 16'hFFFF);
        write_row(12, 16'h8001);
        run_clear(1'b0, n);
        check("clear2_latency", 32'(n),               32'd19);
        check("clear2_lines",   32'(lines_cleared_o), 32'd2);
        tick();
        check("clear2_ready_back", 32'(ready_o),      32'd1);
        check("clear2_done_pulse", 32'(clear_done_o), 32'd0);
        for (int r = 0; r < 16; r++) begin
            read_row(r, d);
            check($sformatf("clear2_row%0d", r), 32'(d), 32'(exp_rows[r]));
        end

        run_clear(1'b1, n);
        check("clear0_latency", 32'(n),               32'd17);
        check("clear0_lines",   32'(lines_cleared_o), 32'd0);
        tick();
        read_row(0, d);
        check("busy_write_ignored_row0", 32'(d), 32'h0000);
        read_row(7, d);
        check("clear0_row7", 32'(d), 32'h0F0F);
        read_row(14, d);
        check("clear0_row14", 32'(d), 32'h8001);

        for (int r = 0; r < 16; r++) write_row(r, 16'hFFFF);
        run_clear(1'b0, n);
        check("clear_all_latency", 32'(n),               32'd33);
        check("clear_all_lines",   32'(lines_cleared_o), 32'd16);
        tick();
        for (int r = 0; r < 16; r++) begin
            read_row(r, d);
            check($sformatf("clear_all_row%0d", r), 32'(d), 32'h0000);
        end

        write_row(15, 16'hFFFF);
        write_row(3,  16'h00FF);
        clear_v_i = 1'b1;
        tick();
        clear_v_i = 1'b0;
        repeat (4) tick();
        #1;
        reset_n_i = 1'b0;
        #1;
        check("abort_ready", 32'(ready_o),         32'd0);
        check("abort_lines", 32'(lines_cleared_o), 32'd0);
        #1;
        reset_n_i = 1'b1;
        #1;
        check("abort_ready_before_edge", 32'(ready_o), 32'd0);
        seen = 1'b0;
        tick();
        check("abort_ready_after_edge", 32'(ready_o), 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (clear_done_o) seen = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(seen), 32'd0);
        read_row(15, d);
        check("abort_row15", 32'(d), 32'h0000);
        read_row(3, d);
        check("abort_row3", 32'(d), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
